rr_arbiter8: RTL and testbench
==============================

RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter: HOLD_MAX, default 16, maximum consecutive cycles one grant may be held; range 2..31; used only when ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 req  input  8  request vector; bit i = requester i wants the shared 3x8-decoded resource.
REQ-005 done  input  1  current grant holder releases; sampled only in state GRANT.
REQ-006 gnt_idx  output  3  binary index of current grant holder.
REQ-007 gnt_vld  output  1  high while a grant is active; drives the decoder enable.
REQ-008 gnt  output  8  one-hot grant; equals 3-to-8 decode of gnt_idx when gnt_vld=1, else 8'h00.
REQ-009 timeout  output  1  one-cycle pulse on forced release; constant 0 when ARB_TIMEOUT_EN is undefined.

Function
REQ-010 Two-state FSM: IDLE, GRANT; all outputs registered or decoded from registers, no combinational path from req/done to outputs.
REQ-011 Internal 3-bit priority pointer ptr; the highest-priority requester is ptr, then ptr+1, ... ptr+7, modulo 8.
REQ-012 IDLE, req==0 -> stay IDLE, outputs unchanged (gnt_vld=0).
REQ-013 IDLE, req!=0 -> at that edge load gnt_idx with the first set bit of req searched from ptr upward with wrap 7->0; set gnt_vld=1; go to GRANT. Latency: req visible at edge N gives gnt_vld=1 after edge N.
REQ-014 GRANT, release condition = done=1 OR req[gnt_idx]=0 (OR forced release, REQ-022).
REQ-015 GRANT with release -> at that edge gnt_vld=0, ptr=gnt_idx+1 (7 wraps to 0), go to IDLE; gnt_idx keeps its last value.
REQ-016 GRANT without release -> hold gnt_idx and gnt_vld; changes on other req bits ignored.
REQ-017 At least one IDLE cycle (gnt_vld=0) between consecutive grants; gnt never has more than one bit set.
REQ-018 done while in IDLE is ignored.
REQ-019 Fairness: with req held at 8'hFF and done pulsed once per grant, no requester is granted twice before every other requester has been granted once.

Reset
REQ-020 rst_n=0 immediately, independent of clk: state=IDLE, ptr=0, gnt_idx=0, gnt_vld=0, gnt=8'h00, timeout=0, hold counter=0.
REQ-021 Reset mid-grant aborts the grant with no release cycle; the first arbitration after rst_n rises starts from ptr=0.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN defined: 5-bit hold counter clears on grant entry and increments each GRANT cycle; if no normal release occurs, the grant is forcibly released so gnt_vld stays high for exactly HOLD_MAX cycles; timeout=1 for the single cycle following the forced-release edge; ptr updates per REQ-015.
REQ-023 Normal release (REQ-014) on the same edge as the forced-release limit is treated as normal; timeout stays 0.
REQ-024 Macro ARB_TIMEOUT_EN undefined: no counter logic, a grant is held indefinitely until done or req drop; timeout tied to 0.

Verification
REQ-025 From reset, req=8'h08 -> after next edge gnt_idx=3, gnt=8'h08, gnt_vld=1; pulse done -> next edge gnt=8'h00; repeat req=8'h08 -> grant 3 again after one IDLE cycle.
REQ-026 From reset, req=8'hFF, done pulsed one cycle after each grant -> grant order 0,1,2,3,4,5,6,7,0, each separated by one gnt_vld=0 cycle.
REQ-027 Wrap: after grant 7 is released, req=8'h81 -> gnt_idx=0 (ptr wrapped to 0), not 7.
REQ-028 req=8'h24, holder 2 drops req[2] without done -> release next edge; following grant goes to 5.
REQ-029 ARB_TIMEOUT_EN, HOLD_MAX=4, req=8'h01 held, done=0 -> gnt_vld high exactly 4 cycles, then timeout=1 for one cycle, then grant 0 again; without macro gnt_vld stays high for 100+ cycles with timeout=0.
REQ-030 rst_n driven low between clock edges during GRANT with gnt=8'h10 -> gnt=8'h00, gnt_vld=0 immediately; after release of reset with req=8'hFF, first grant is 0.

Source files
------------

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters. Optional ARB_TIMEOUT_EN forces release after HOLD_MAX cycles.
// Latency: req seen at edge N gives a registered grant after edge N; at least one idle cycle between grants.
// Backpressure: the holder keeps the grant until done, its req bit drops, or the hold limit is reached.
module rr_arbiter8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic [7:0] gnt,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic [2:0] pick_idx;
    logic [2:0] scan_idx;
    logic       pick_vld;
    logic       norm_rel;
    logic       force_rel;

    generate
        if (HOLD_MAX < 2 || HOLD_MAX > 31) begin : g_bad_hold
            $error("rr_arbiter8: HOLD_MAX must be within 2..31");
        end
    endgenerate

    // Scan from the farthest offset down so the last hit is the one closest to ptr.
    always_comb begin
        pick_idx = 3'd0;
        pick_vld = 1'b0;
        scan_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            scan_idx = ptr_q + 3'(k);
            if (req[scan_idx]) begin
                pick_idx = scan_idx;
                pick_vld = 1'b1;
            end
        end
    end

    assign norm_rel = done | ~req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
    logic [4:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;

    assign force_rel = (hold_cnt_q == 5'(HOLD_MAX - 1));

    // A normal release on the limit edge wins, so timeout only flags a true force.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        if (state_q == IDLE) begin
            hold_cnt_d = 5'd0;
        end else if (norm_rel || force_rel) begin
            hold_cnt_d = 5'd0;
            timeout_d  = force_rel & ~norm_rel;
        end else begin
            hold_cnt_d = hold_cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= 5'd0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_idx_d = pick_idx;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                if (norm_rel || force_rel) begin
                    ptr_d   = gnt_idx_q + 3'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            gnt_idx_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = (state_q == GRANT);
    assign gnt     = gnt_vld ? (8'h01 << gnt_idx_q) : 8'h00;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed sequences with expected outputs queued per driven cycle.
// Works with or without ARB_TIMEOUT_EN; the DUT is built with HOLD_MAX=4.
module tb_rr_arbiter8;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic [7:0] gnt;
    logic       timeout;

    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
        logic       to;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    rr_arbiter8 #(.HOLD_MAX(HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .gnt     (gnt),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of stimulus, queue what the outputs must be after the edge, then compare.
    task automatic step(input logic [7:0] r, input logic d, input logic vld,
                        input logic [2:0] idx, input logic to, input string tag);
        exp_t e;
        logic [7:0] eg;
        @(negedge clk);
        req  = r;
        done = d;
        e.vld = vld;
        e.idx = idx;
        e.to  = to;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e  = sb_q.pop_front();
        eg = e.vld ? (8'h01 << e.idx) : 8'h00;
        chk({tag, "/vld"}, 16'(gnt_vld), 16'(e.vld));
        chk({tag, "/idx"}, 16'(gnt_idx), 16'(e.idx));
        chk({tag, "/gnt"}, 16'(gnt), 16'(eg));
        chk({tag, "/timeout"}, 16'(timeout), 16'(e.to));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "/vld"}, 16'(gnt_vld), 16'd0);
        chk({tag, "/idx"}, 16'(gnt_idx), 16'd0);
        chk({tag, "/gnt"}, 16'(gnt), 16'd0);
        chk({tag, "/timeout"}, 16'(timeout), 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, release by done, re-grant after one idle cycle.
        step(8'h08, 1'b0, 1'b1, 3'd3, 1'b0, "r3_grant");
        step(8'h08, 1'b1, 1'b0, 3'd3, 1'b0, "r3_done");
        step(8'h08, 1'b0, 1'b1, 3'd3, 1'b0, "r3_regrant");
        step(8'h00, 1'b0, 1'b0, 3'd3, 1'b0, "r3_drop");

        // Asynchronous reset between edges restores ptr to 0.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst2");
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness rotation with all requesters active.
        for (int i = 0; i < 8; i++) begin
            step(8'hFF, 1'b0, 1'b1, 3'(i), 1'b0, $sformatf("rot%0d_grant", i));
            step(8'hFF, 1'b1, 1'b0, 3'(i), 1'b0, $sformatf("rot%0d_rel", i));
        end
        // Pointer wrapped to 0 after 7: 0 wins over 7, then 7 wins from ptr=1.
        step(8'h81, 1'b0, 1'b1, 3'd0, 1'b0, "wrap_grant0");
        step(8'h81, 1'b1, 1'b0, 3'd0, 1'b0, "wrap_rel0");
        step(8'h81, 1'b0, 1'b1, 3'd7, 1'b0, "wrap_grant7");
        step(8'h81, 1'b1, 1'b0, 3'd7, 1'b0, "wrap_rel7");

        // Release by dropping own req bit; other req changes ignored while granted.
        step(8'h24, 1'b0, 1'b1, 3'd2, 1'b0, "drop_grant2");
        step(8'h20, 1'b0, 1'b0, 3'd2, 1'b0, "drop_rel2");
        step(8'h24, 1'b0, 1'b1, 3'd5, 1'b0, "drop_grant5");
        step(8'hFF, 1'b0, 1'b1, 3'd5, 1'b0, "hold5_ignore");
        step(8'hFF, 1'b1, 1'b0, 3'd5, 1'b0, "rel5");

        // done while idle has no effect.
        step(8'h00, 1'b1, 1'b0, 3'd5, 1'b0, "idle_done");
        step(8'h00, 1'b0, 1'b0, 3'd5, 1'b0, "idle_quiet");

`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < HOLD; i++)
            step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, $sformatf("to_hold%0d", i));
        step(8'h01, 1'b0, 1'b0, 3'd0, 1'b1, "to_force");
        step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, "to_regrant");
        for (int i = 1; i < HOLD; i++)
            step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, $sformatf("to2_hold%0d", i));
        step(8'h01, 1'b1, 1'b0, 3'd0, 1'b0, "to_done_on_limit");
        step(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "to_idle");
`else
        for (int i = 0; i < 120; i++)
            step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, $sformatf("long_hold%0d", i));
        step(8'h01, 1'b1, 1'b0, 3'd0, 1'b0, "long_rel");
        step(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "long_idle");
`endif

        // Reset asserted mid-grant of requester 4 clears outputs at once.
        step(8'h10, 1'b0, 1'b1, 3'd4, 1'b0, "g4_grant");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midgrant_rst");
        @(negedge clk);
        req   = 8'h00;
        rst_n = 1'b1;
        step(8'hFF, 1'b0, 1'b1, 3'd0, 1'b0, "post_rst_grant");
        chk("sb_empty", 16'(sb_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
